// File: rtl/conv_layer_seq.sv
// Sequential multi-channel, multi-kernel valid convolution built on a single multiply-accumulate unit.
// Latency: IN_CH*K*K+1 cycles per output point; done fires one cycle after the last point is written.
// Backpressure: none; every point is strobed once on out_valid and also kept in the featuremap2 array.
module conv_layer_seq #(
  parameter int BITWIDTH = 32,
  parameter int IN_CH    = 2,
  parameter int OUT_CH   = 2,
  parameter int IN_SIZE  = 14,
  parameter int K        = 5,
  parameter int RELU     = 0,
  localparam int OUT_SIZE = IN_SIZE - K + 1,
  localparam int OCW      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  localparam int OSW      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BITWIDTH-1:0] featuremap1 [IN_CH][IN_SIZE][IN_SIZE],
  input  logic [BITWIDTH-1:0] kernel      [OUT_CH][IN_CH][K][K],
  output logic [BITWIDTH-1:0] featuremap2 [OUT_CH][OUT_SIZE][OUT_SIZE],
  output logic                out_valid,
  output logic [BITWIDTH-1:0] out_data,
  output logic [OCW-1:0]      out_ch,
  output logic [OSW-1:0]      out_row,
  output logic [OSW-1:0]      out_col,
  output logic                busy,
  output logic                done
);

  localparam int ICW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int ISW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;

  state_t              state;
  logic [BITWIDTH-1:0] acc;
  logic [ICW-1:0]      ic;
  logic [KW-1:0]       kr, kc;
  logic [OCW-1:0]      oc;
  logic [OSW-1:0]      row, col;

  logic [ISW-1:0]      tap_row, tap_col;
  logic [BITWIDTH-1:0] tap_prod;
  logic [BITWIDTH-1:0] res;
  logic                last_point;

  // Input pixel under the current tap; the product keeps only the low BITWIDTH bits.
  assign tap_row  = ISW'(row) + ISW'(kr);
  assign tap_col  = ISW'(col) + ISW'(kc);
  assign tap_prod = featuremap1[ic][tap_row][tap_col] * kernel[oc][ic][kr][kc];

  // ReLU only looks at the sign bit, so the datapath stays unsigned throughout.
  assign res = ((RELU != 0) && acc[BITWIDTH-1]) ? '0 : acc;

  assign last_point = (oc == OCW'(OUT_CH - 1)) && (row == OSW'(OUT_SIZE - 1)) &&
                      (col == OSW'(OUT_SIZE - 1));

  // Control FSM: walks taps (ic, kr, kc) inside points (oc, row, col) and drives the stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ic        <= '0;
      kr        <= '0;
      kc        <= '0;
      oc        <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
            ic    <= '0;
            kr    <= '0;
            kc    <= '0;
            oc    <= '0;
            row   <= '0;
            col   <= '0;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          acc <= acc + tap_prod;
          if (kc != KW'(K - 1)) begin
            kc <= kc + 1'b1;
          end else begin
            kc <= '0;
            if (kr != KW'(K - 1)) begin
              kr <= kr + 1'b1;
            end else begin
              kr <= '0;
              if (ic != ICW'(IN_CH - 1)) begin
                ic <= ic + 1'b1;
              end else begin
                ic    <= '0;
                state <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          out_data  <= res;
          out_ch    <= oc;
          out_row   <= row;
          out_col   <= col;
          out_valid <= 1'b1;
          acc       <= '0;
          if (col != OSW'(OUT_SIZE - 1)) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            if (row != OSW'(OUT_SIZE - 1)) begin
              row <= row + 1'b1;
            end else begin
              row <= '0;
              if (oc != OCW'(OUT_CH - 1)) oc <= oc + 1'b1;
              else                        oc <= '0;
            end
          end
          if (last_point) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result storage: each entry only changes when its own point is written, so stale entries persist.
  for (genvar go = 0; go < OUT_CH; go++) begin : g_och
    for (genvar gr = 0; gr < OUT_SIZE; gr++) begin : g_row
      for (genvar gc = 0; gc < OUT_SIZE; gc++) begin : g_col
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            featuremap2[go][gr][gc] <= '0;
          else if ((state == WRITE) && (oc == OCW'(go)) && (row == OSW'(gr)) && (col == OSW'(gc)))
            featuremap2[go][gr][gc] <= res;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: default-size instance (RELU=0) and a small instance (RELU=1).
// Each run is compared point by point against a plain-loop convolution model.
// Timing of every out_valid and done is checked against start, plus reset and restart behaviour.
module tb_conv_layer_seq;

  // Default-size instance
  localparam int A_IC = 2, A_OC = 2, A_IS = 14, A_K = 5, A_OS = 10;
  localparam int A_N  = A_IC * A_K * A_K + 1;
  localparam int A_NP = A_OC * A_OS * A_OS;
  // Small instance with ReLU
  localparam int B_IC = 1, B_OC = 3, B_IS = 6, B_K = 3, B_OS = 4;
  localparam int B_N  = B_IC * B_K * B_K + 1;
  localparam int B_NP = B_OC * B_OS * B_OS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_start, a_ov, a_busy, a_done;
  logic [31:0] a_fm1 [A_IC][A_IS][A_IS];
  logic [31:0] a_ker [A_OC][A_IC][A_K][A_K];
  logic [31:0] a_fm2 [A_OC][A_OS][A_OS];
  logic [31:0] a_od;
  logic [0:0]  a_och;
  logic [3:0]  a_orow, a_ocol;
  logic [31:0] exp_a [A_OC][A_OS][A_OS];

  logic        b_start, b_ov, b_busy, b_done;
  logic [31:0] b_fm1 [B_IC][B_IS][B_IS];
  logic [31:0] b_ker [B_OC][B_IC][B_K][B_K];
  logic [31:0] b_fm2 [B_OC][B_OS][B_OS];
  logic [31:0] b_od;
  logic [1:0]  b_och;
  logic [1:0]  b_orow, b_ocol;
  logic [31:0] exp_b [B_OC][B_OS][B_OS];

  int n_chk  = 0;
  int n_fail = 0;

  conv_layer_seq #(.BITWIDTH(32), .IN_CH(A_IC), .OUT_CH(A_OC), .IN_SIZE(A_IS), .K(A_K), .RELU(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .featuremap1(a_fm1), .kernel(a_ker),
    .featuremap2(a_fm2), .out_valid(a_ov), .out_data(a_od), .out_ch(a_och),
    .out_row(a_orow), .out_col(a_ocol), .busy(a_busy), .done(a_done));

  conv_layer_seq #(.BITWIDTH(32), .IN_CH(B_IC), .OUT_CH(B_OC), .IN_SIZE(B_IS), .K(B_K), .RELU(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .featuremap1(b_fm1), .kernel(b_ker),
    .featuremap2(b_fm2), .out_valid(b_ov), .out_data(b_od), .out_ch(b_och),
    .out_row(b_orow), .out_col(b_ocol), .busy(b_busy), .done(b_done));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: direct valid convolution, modulo 2^32.
  task automatic model_a();
    logic [31:0] s;
    for (int o = 0; o < A_OC; o++)
      for (int r = 0; r < A_OS; r++)
        for (int x = 0; x < A_OS; x++) begin
          s = 32'd0;
          for (int i = 0; i < A_IC; i++)
            for (int u = 0; u < A_K; u++)
              for (int v = 0; v < A_K; v++)
                s = s + a_fm1[i][r+u][x+v] * a_ker[o][i][u][v];
          exp_a[o][r][x] = s;
        end
  endtask

  task automatic model_b();
    logic [31:0] s;
    for (int o = 0; o < B_OC; o++)
      for (int r = 0; r < B_OS; r++)
        for (int x = 0; x < B_OS; x++) begin
          s = 32'd0;
          for (int i = 0; i < B_IC; i++)
            for (int u = 0; u < B_K; u++)
              for (int v = 0; v < B_K; v++)
                s = s + b_fm1[i][r+u][x+v] * b_ker[o][i][u][v];
          exp_b[o][r][x] = s[31] ? 32'd0 : s;
        end
  endtask

  // mode: 0 ones/ones, 1 ramp/centre-tap identity, 2 random, 3 ones/all-ones-bits, 4 0x10000 everywhere
  task automatic set_a(input int mode);
    for (int c = 0; c < A_IC; c++)
      for (int r = 0; r < A_IS; r++)
        for (int x = 0; x < A_IS; x++)
          case (mode)
            1:       a_fm1[c][r][x] = 32'(100 * c + r * 14 + x);
            2:       a_fm1[c][r][x] = $urandom;
            4:       a_fm1[c][r][x] = 32'h0001_0000;
            default: a_fm1[c][r][x] = 32'd1;
          endcase
    for (int o = 0; o < A_OC; o++)
      for (int i = 0; i < A_IC; i++)
        for (int u = 0; u < A_K; u++)
          for (int v = 0; v < A_K; v++)
            case (mode)
              1:       a_ker[o][i][u][v] = (i == o && u == 2 && v == 2) ? 32'd1 : 32'd0;
              2:       a_ker[o][i][u][v] = $urandom;
              3:       a_ker[o][i][u][v] = 32'hFFFF_FFFF;
              4:       a_ker[o][i][u][v] = 32'h0001_0000;
              default: a_ker[o][i][u][v] = 32'd1;
            endcase
    model_a();
  endtask

  task automatic set_b(input int mode);
    for (int r = 0; r < B_IS; r++)
      for (int x = 0; x < B_IS; x++)
        b_fm1[0][r][x] = (mode == 2) ? $urandom : 32'd1;
    for (int o = 0; o < B_OC; o++)
      for (int u = 0; u < B_K; u++)
        for (int v = 0; v < B_K; v++)
          case (mode)
            2:       b_ker[o][0][u][v] = $urandom;
            3:       b_ker[o][0][u][v] = 32'hFFFF_FFFF;
            default: b_ker[o][0][u][v] = 32'd1;
          endcase
    model_b();
  endtask

  // One full layer on dut_a. cyc counts edges after the start edge; sampling is on negedges.
  task automatic run_a(input bit do_pulse, input bit repulse, input bit chain);
    int cyc, cnt, o, r, x;
    bit fin;
    if (do_pulse) begin
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
    end
    chk("a_busy_at_start", a_busy, 1);
    cyc = 0; cnt = 0; fin = 1'b0;
    while (!fin && cyc < A_NP * A_N + 20) begin
      @(negedge clk);
      cyc++;
      if (repulse) a_start = (cyc == 100);
      if (a_ov) begin
        o = cnt / (A_OS * A_OS); r = (cnt / A_OS) % A_OS; x = cnt % A_OS;
        chk("a_valid_time", cyc, (cnt + 1) * A_N);
        chk("a_out_data", a_od, exp_a[o][r][x]);
        chk("a_out_coord", (32'(a_och) << 8) | (32'(a_orow) << 4) | 32'(a_ocol), 32'(o * 256 + r * 16 + x));
        cnt++;
      end
      if (a_done) begin
        fin = 1'b1;
        chk("a_done_time", cyc, A_NP * A_N);
        chk("a_point_count", cnt, A_NP);
        chk("a_busy_at_done", a_busy, 0);
        for (int oo = 0; oo < A_OC; oo++)
          for (int rr = 0; rr < A_OS; rr++)
            for (int xx = 0; xx < A_OS; xx++)
              chk("a_fm2", a_fm2[oo][rr][xx], exp_a[oo][rr][xx]);
      end
    end
    chk("a_done_seen", fin, 1);
    if (chain) a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("a_valid_one_cycle", a_ov, 0);
    chk("a_done_one_cycle", a_done, 0);
    chk("a_busy_after_done", a_busy, chain);
  endtask

  task automatic run_b();
    int cyc, cnt, o, r, x;
    bit fin;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    cyc = 0; cnt = 0; fin = 1'b0;
    while (!fin && cyc < B_NP * B_N + 20) begin
      @(negedge clk);
      cyc++;
      if (b_ov) begin
        o = cnt / (B_OS * B_OS); r = (cnt / B_OS) % B_OS; x = cnt % B_OS;
        chk("b_valid_time", cyc, (cnt + 1) * B_N);
        chk("b_out_data", b_od, exp_b[o][r][x]);
        chk("b_out_coord", (32'(b_och) << 8) | (32'(b_orow) << 4) | 32'(b_ocol), 32'(o * 256 + r * 16 + x));
        cnt++;
      end
      if (b_done) begin
        fin = 1'b1;
        chk("b_done_time", cyc, B_NP * B_N);
        chk("b_point_count", cnt, B_NP);
        for (int oo = 0; oo < B_OC; oo++)
          for (int rr = 0; rr < B_OS; rr++)
            for (int xx = 0; xx < B_OS; xx++)
              chk("b_fm2", b_fm2[oo][rr][xx], exp_b[oo][rr][xx]);
      end
    end
    chk("b_done_seen", fin, 1);
    @(negedge clk);
    chk("b_done_one_cycle", b_done, 0);
  endtask

  initial begin
    int cyc, cnt, nz;
    rst_n = 1'b1; a_start = 1'b1; b_start = 1'b1;
    set_a(0); set_b(0);

    // Asynchronous reset in mid-cycle with start held high.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_valid", a_ov, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_data", a_od, 0);
    chk("rst_a_fm2_first", a_fm2[0][0][0], 0);
    chk("rst_a_fm2_last", a_fm2[1][9][9], 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_fm2", b_fm2[2][3][3], 0);
    repeat (3) @(negedge clk);
    a_start = 1'b0; b_start = 1'b0; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_start_busy", a_busy, 0);
    chk("idle_no_start_valid", a_ov, 0);

    // All ones: every point sums 50 ones.
    run_a(1, 0, 0);
    chk("ones_value", a_fm2[1][9][9], 32'd50);

    // Centre-tap identity, start re-pulsed mid-run, then a back-to-back run started in the done cycle.
    set_a(1);
    run_a(1, 1, 1);
    chk("centre_value", a_fm2[1][3][4], 32'(100 + 5 * 14 + 6));
    run_a(0, 0, 0);

    // Random data, aborted by reset once point 37 has been written.
    set_a(2);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    cyc = 0; cnt = 0;
    while (cnt < 38 && cyc < 38 * A_N + 20) begin
      @(negedge clk);
      cyc++;
      if (a_ov) cnt++;
    end
    chk("abort_reached_point", cnt, 38);
    #2 rst_n = 1'b0; a_start = 1'b1;
    #1;
    nz = 0;
    for (int o = 0; o < A_OC; o++)
      for (int r = 0; r < A_OS; r++)
        for (int x = 0; x < A_OS; x++)
          if (a_fm2[o][r][x] !== 32'd0) nz++;
    chk("abort_fm2_cleared", nz, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_valid", a_ov, 0);
    chk("abort_coord", (32'(a_och) << 8) | (32'(a_orow) << 4) | 32'(a_ocol), 0);
    @(negedge clk);
    a_start = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", a_busy, 0);
    run_a(1, 0, 0);

    // Negative sum without ReLU, then a product that wraps to zero.
    set_a(3);
    run_a(1, 0, 0);
    chk("neg_value", a_fm2[0][0][0], 32'hFFFF_FFCE);
    set_a(4);
    run_a(1, 0, 0);
    chk("wrap_value", a_fm2[0][5][5], 32'd0);

    // Small instance with ReLU.
    set_b(0);
    run_b();
    chk("b_ones_value", b_fm2[0][0][0], 32'd9);
    set_b(3);
    run_b();
    chk("b_relu_clamp", b_fm2[2][3][3], 32'd0);
    set_b(2);
    run_b();
    set_b(2);
    run_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_seq.md
Name: conv_layer_seq

Overview:
- Parametrised, time-multiplexed successor to the fully-unrolled convolution layers: one multiply-accumulate unit computes a multi-channel, multi-kernel valid convolution sequentially.
- Sits between feature-map storage and the next layer.
- Each output point is written into a registered output array and also streamed with a one-cycle valid strobe.
- Adds start/busy/done control, optional ReLU and generic sizes.

Parameters:
- BITWIDTH, 32, data width of features, weights and results
- IN_CH, 2, input channels
- OUT_CH, 2, output channels (kernel count)
- IN_SIZE, 14, input feature-map height = width
- K, 5, kernel height = width; OUT_SIZE = IN_SIZE-K+1 (derived localparam, must be >= 1)
- RELU, 0, 1 = clamp results with MSB set to 0

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a layer computation; sampled only in IDLE
- featuremap1  in  BITWIDTH x [IN_CH][IN_SIZE][IN_SIZE]  input maps; must be stable while busy
- kernel  in  BITWIDTH x [OUT_CH][IN_CH][K][K]  weights; must be stable while busy
- featuremap2  out  BITWIDTH x [OUT_CH][OUT_SIZE][OUT_SIZE]  registered result array
- out_valid  out  1  one-cycle strobe per completed output point
- out_data  out  BITWIDTH  value of the point just written
- out_ch, out_row, out_col  out  max(1,$clog2(OUT_CH)), max(1,$clog2(OUT_SIZE)) each  coordinates of out_data
- busy  out  1  computation in progress
- done  out  1  one-cycle strobe when the last point is written

Behaviour:
- Reset (async assert, sync release): state IDLE; all featuremap2 entries, accumulator, counters, out_* and done are 0; busy is 0.
- FSM has three states.
- IDLE: on an edge with start=1, enter ACCUM with all counters 0 and acc=0; busy<=1.
- ACCUM: each edge acc <= acc + featuremap1[ic][row+kr][col+kc] * kernel[oc][ic][kr][kc]. Advance kc, then kr, then ic. The edge that consumes the last tap (ic=IN_CH-1, kr=kc=K-1) enters WRITE.
- WRITE: one edge.
  - featuremap2[oc][row][col] <= res, where res = (RELU && acc[BITWIDTH-1]) ? 0 : acc.
  - out_data <= res; out_ch/row/col <= oc/row/col; out_valid <= 1; acc <= 0.
  - Advance col, then row, then oc. If the point was the last one, go IDLE with busy<=0 and done<=1. Otherwise go ACCUM.
- Point order: oc outermost, then row, then col. Tap order: ic, kr, kc.
- Arithmetic: unsigned product truncated to BITWIDTH LSBs, accumulated modulo 2^BITWIDTH. This is bit-identical to two's-complement, so signed data works. ReLU only inspects the MSB.
- Timing: N = IN_CH*K*K + 1 cycles per point.
  - With start sampled at edge E0, point p (0-based) is written at edge E0 + (p+1)*N.
  - done and the final out_valid are high together for the cycle after edge E0 + OUT_CH*OUT_SIZE²*N.
  - Defaults: N = 51; done after edge E0 + 10200.
- out_valid and done are high exactly one cycle. out_data/out_ch/out_row/out_col hold their values until the next write.
- featuremap2 entries not yet rewritten keep their previous contents. A new run overwrites all entries.
- start while busy is ignored. start during the done cycle is accepted, because the state is already IDLE (back-to-back runs).
- Reset mid-run aborts immediately and clears everything, including featuremap2.
- Changing featuremap1 or kernel while busy gives undefined results. This is not checked.

Test Plan:
- Reset: rst_n low mid-cycle with start=1 -> all outputs 0 asynchronously; no activity until rst_n=1 and start pulses.
- Defaults, featuremap1 all 1, kernel all 1 -> all 200 featuremap2 entries = 50; exactly 200 out_valid pulses spaced 51 cycles; coordinates in order (0,0,0) to (1,9,9); done once, 10200 cycles after start.
- Defaults, featuremap1[c][r][x] = 100*c+r*14+x, kernel[o][i] = 1 only at the centre [2][2] for i=o, else 0 -> featuremap2[o][r][x] = featuremap1[o][r+2][x+2].
- featuremap1 = 1, kernel = 0xFFFFFFFF: RELU=0 -> every output 0xFFFFFFCE; RELU=1 -> every output 0. Then featuremap1 = 0x10000, kernel = 0x10000 -> outputs 0 (wrap).
- start re-pulsed while busy -> ignored, same timing. rst_n pulsed at point 37 -> busy=0, featuremap2 cleared. A later start reruns the full layer correctly. start during the done cycle -> second run starts immediately.
- IN_CH=1, OUT_CH=3, IN_SIZE=6, K=3, random data -> matches golden model bit-exactly. N=10, done after 3*16*10=480 cycles.
